// File: rtl/cpu_pkg.sv
// Shared types, opcode masks and decode helpers for the cpu_core_p core.
package cpu_pkg;

    typedef enum logic [2:0] {S_F1, S_F2, S_EX, S_MEM, S_HALTED} state_e;
    typedef enum logic [2:0] {G_CONST, G_BRANCH, G_REG, G_MEM, G_OTHERS, G_ILLEGAL} group_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV, ALU_CMP
    } alu_op_e;
    typedef enum logic [2:0] {C_ALWAYS, C_Z, C_NZ, C_C, C_NC, C_N, C_V, C_NV} cond_e;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
        logic n;
    } flags_t;

    localparam logic [3:0] REG_MATCH = 4'b0111;
    localparam logic [4:0] MEM_MATCH = 5'b01111;
    localparam logic [4:0] OTH_MATCH = 5'b11111;

    function automatic group_e decode_group(input logic [7:0] b);
        if (!b[0]) return G_CONST;
        if (b[1:0] == 2'b01) return G_BRANCH;
        if (b[3:0] == REG_MATCH) return G_REG;
        if (b[4:0] == MEM_MATCH) return G_MEM;
        if (b[4:0] == OTH_MATCH) return G_OTHERS;
        return G_ILLEGAL;
    endfunction

    function automatic alu_op_e const_op(input logic [2:0] op);
        case (op)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SUB;
            3'b010:  return ALU_AND;
            3'b011:  return ALU_OR;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_MOV;
            3'b110:  return ALU_CMP;
            default: return ALU_ADC;
        endcase
    endfunction

    function automatic logic reg_op_valid(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic alu_op_e reg_op(input logic [3:0] op);
        case (op)
            4'h1:    return ALU_ADC;
            4'h2:    return ALU_SUB;
            4'h3:    return ALU_SBC;
            4'h4:    return ALU_AND;
            4'h6:    return ALU_OR;
            4'h8:    return ALU_XOR;
            4'hA:    return ALU_MOV;
            4'hC:    return ALU_CMP;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic cond_true(input cond_e c, input flags_t f);
        case (c)
            C_ALWAYS: return 1'b1;
            C_Z:      return f.z;
            C_NZ:     return !f.z;
            C_C:      return f.c;
            C_NC:     return !f.c;
            C_N:      return f.n;
            C_V:      return f.v;
            default:  return !f.v;
        endcase
    endfunction

endpackage

// File: rtl/cpu_core_p_if.sv
// Address/strobe/ready handshake of the shared memory bus.
interface cpu_core_p_if;
    logic [15:0] adress_bus;
    logic        r;
    logic        w;
    logic        ready;

    modport master (output adress_bus, r, w, input ready);
    modport slave  (input adress_bus, r, w, output ready);
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU shared by immediate and register arithmetic groups.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  alu_op_e    op_i,
    input  logic       cin_i,
    input  flags_t     flags_i,
    output logic [7:0] result_o,
    output flags_t     flags_o,
    output logic       writes_rd_o
);
    logic [8:0] sum;

    always_comb begin
        sum         = 9'd0;
        result_o    = 8'h00;
        flags_o     = flags_i;
        writes_rd_o = 1'b1;
        case (op_i)
            ALU_ADD, ALU_ADC: begin
                sum       = {1'b0, a_i} + {1'b0, b_i} + {8'd0, (op_i == ALU_ADC) & cin_i};
                result_o  = sum[7:0];
                flags_o.c = sum[8];
                flags_o.v = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
            end
            ALU_SUB, ALU_SBC, ALU_CMP: begin
                // bit 8 of the 9-bit difference is the borrow
                sum         = {1'b0, a_i} - {1'b0, b_i} - {8'd0, (op_i == ALU_SBC) & cin_i};
                result_o    = sum[7:0];
                flags_o.c   = sum[8];
                flags_o.v   = (a_i[7] != b_i[7]) && (sum[7] != a_i[7]);
                writes_rd_o = (op_i != ALU_CMP);
            end
            ALU_AND: begin result_o = a_i & b_i; flags_o.v = 1'b0; end
            ALU_OR:  begin result_o = a_i | b_i; flags_o.v = 1'b0; end
            ALU_XOR: begin result_o = a_i ^ b_i; flags_o.v = 1'b0; end
            ALU_MOV: result_o = b_i;
            default: writes_rd_o = 1'b0;
        endcase
        flags_o.z = (result_o == 8'h00);
        flags_o.n = result_o[7];
    end
endmodule

// File: rtl/cpu_core_p.sv
// 8-bit bus CPU core: 16 registers, R8..R15 paired as ER0..ER3, ready-based wait states.
//   state    | meaning
//   S_F1     | fetch opcode byte at pc
//   S_F2     | fetch second byte (immediate / offset / operands)
//   S_EX     | execute, or dispatch to S_MEM / S_HALTED
//   S_MEM    | load or store through an ER pair
//   S_HALTED | stopped until reset
module cpu_core_p
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h2000,
    parameter int unsigned WAIT_MAX     = 15,
    parameter bit          TRACE        = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    cpu_core_p_if.master bus,
    inout  wire  [7:0]   date_bus,
    output logic         halt,
    output logic         illegal,
    output logic         bus_err
);
    localparam logic [15:0] WAIT_LIM = 16'(WAIT_MAX);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d, imm_q, imm_d;
    logic [7:0]  regs_q [16];
    logic [7:0]  regs_d [16];
    flags_t      flags_q, flags_d;
    logic [15:0] wait_q, wait_d;
    logic        halt_q, halt_d, illegal_q, illegal_d, bus_err_q, bus_err_d;

    logic        r_c, w_c, bus_wait;
    logic [15:0] addr_c, er_addr;
    group_e      grp;
    alu_op_e     alu_op;
    logic        alu_ok, alu_wr;
    logic [3:0]  rd_idx;
    logic [7:0]  alu_b, alu_res;
    flags_t      alu_flags;

    assign grp     = decode_group(ir_q);
    assign er_addr = {regs_q[{1'b1, ir_q[7:6], 1'b1}], regs_q[{1'b1, ir_q[7:6], 1'b0}]};

    always_comb begin
        if (grp == G_CONST) begin
            alu_op = const_op(ir_q[3:1]);
            alu_ok = 1'b1;
            rd_idx = ir_q[7:4];
            alu_b  = imm_q;
        end else begin
            alu_op = reg_op(ir_q[7:4]);
            alu_ok = reg_op_valid(ir_q[7:4]);
            rd_idx = imm_q[3:0];
            alu_b  = regs_q[imm_q[7:4]];
        end
    end

    cpu_alu u_alu (
        .a_i        (regs_q[rd_idx]),
        .b_i        (alu_b),
        .op_i       (alu_op),
        .cin_i      (flags_q.c),
        .flags_i    (flags_q),
        .result_o   (alu_res),
        .flags_o    (alu_flags),
        .writes_rd_o(alu_wr)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        regs_d    = regs_q;
        flags_d   = flags_q;
        wait_d    = wait_q;
        halt_d    = halt_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        r_c       = 1'b0;
        w_c       = 1'b0;
        addr_c    = pc_q;
        bus_wait  = 1'b0;
        case (state_q)
            S_F1, S_F2: begin
                r_c = 1'b1;
                if (bus.ready) begin
                    wait_d = 16'd0;
                    pc_d   = pc_q + 16'd1;
                    if (state_q == S_F1) begin
                        ir_d    = date_bus;
                        state_d = S_F2;
                    end else begin
                        imm_d   = date_bus;
                        state_d = S_EX;
                    end
                end else begin
                    bus_wait = 1'b1;
                end
            end
            S_EX: begin
                state_d = S_F1;
                case (grp)
                    G_CONST, G_REG: begin
                        if (alu_ok) begin
                            if (alu_wr) regs_d[rd_idx] = alu_res;
                            flags_d = alu_flags;
                        end else begin
                            state_d   = S_HALTED;
                            halt_d    = 1'b1;
                            illegal_d = 1'b1;
                        end
                    end
                    G_BRANCH: begin
                        if (cond_true(cond_e'(ir_q[4:2]), flags_q))
                            pc_d = pc_q + {{8{imm_q[7]}}, imm_q};
                    end
                    G_MEM: state_d = S_MEM;
                    G_OTHERS: begin
                        case (ir_q[7:5])
                            3'b000: flags_d.c = 1'b0;
                            3'b001: flags_d.z = 1'b0;
                            3'b010: flags_d.v = 1'b0;
                            3'b011: flags_d.n = 1'b0;
                            3'b110: ;
                            3'b111: begin state_d = S_HALTED; halt_d = 1'b1; end
                            default: begin
                                state_d   = S_HALTED;
                                halt_d    = 1'b1;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        state_d   = S_HALTED;
                        halt_d    = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                addr_c = er_addr;
                r_c    = !ir_q[5];
                w_c    = ir_q[5];
                if (bus.ready) begin
                    wait_d  = 16'd0;
                    state_d = S_F1;
                    if (!ir_q[5]) begin
                        regs_d[imm_q[3:0]] = date_bus;
                        flags_d.z          = (date_bus == 8'h00);
                        flags_d.n          = date_bus[7];
                    end
                end else begin
                    bus_wait = 1'b1;
                end
            end
            default: ;
        endcase
        // the access that reaches the limit is abandoned; strobes drop next cycle
        if (bus_wait) begin
            wait_d = wait_q + 16'd1;
            if (WAIT_MAX != 0 && wait_d == WAIT_LIM) begin
                state_d   = S_HALTED;
                halt_d    = 1'b1;
                bus_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_F1;
            pc_q      <= RESET_VECTOR;
            ir_q      <= 8'h00;
            imm_q     <= 8'h00;
            flags_q   <= '0;
            wait_q    <= 16'd0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            imm_q     <= imm_d;
            flags_q   <= flags_d;
            wait_q    <= wait_d;
            halt_q    <= halt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            regs_q    <= regs_d;
        end
    end

    // strobes and address are gated by reset so an asserted reset drops them at once
    assign bus.r          = reset & r_c;
    assign bus.w          = reset & w_c;
    assign bus.adress_bus = reset ? addr_c : 16'h0000;
    assign date_bus       = (reset && w_c) ? regs_q[imm_q[3:0]] : 8'bz;
    assign halt           = halt_q;
    assign illegal        = illegal_q;
    assign bus_err        = bus_err_q;
endmodule
